// File: rtl/display_arbiter_if.sv
// Display arbiter bus: three requesters' request/payload lines in, one arbitrated display stream out.
interface display_arbiter_if #(
   parameter int DATA_W = 32
);
   logic [2:0]        req;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic [3:0]        lcd0;
   logic [3:0]        lcd1;
   logic [3:0]        lcd2;
   logic [2:0]        grant;
   logic [DATA_W-1:0] display_data;
   logic [3:0]        lcd_select;
   logic              busy;

   modport master (
      output req, data0, data1, data2, lcd0, lcd1, lcd2,
      input  grant, display_data, lcd_select, busy
   );

   modport slave (
      input  req, data0, data1, data2, lcd0, lcd1, lcd2,
      output grant, display_data, lcd_select, busy
   );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 7-segment/LCD display between access control, game and scoreboard.
// An owner keeps the display for at least HOLD_CYCLES cycles. It is forced off after MAX_OWN cycles,
// but only if someone else is waiting. Each release is followed by a one-cycle GAP.
module display_arbiter #(
   parameter int HOLD_CYCLES = 16,
   parameter int MAX_OWN     = 1024,
   parameter int DATA_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   display_arbiter_if.slave bus
);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int OW = (MAX_OWN > 1) ? $clog2(MAX_OWN) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [OW-1:0] OWN_LAST  = OW'(MAX_OWN - 1);

   typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        last_owner_q, last_owner_d;
   logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
   logic [OW-1:0]     own_cnt_q, own_cnt_d;
   logic [2:0]        grant_q, grant_d;
   logic [DATA_W-1:0] display_data_q, display_data_d;
   logic [3:0]        lcd_select_q, lcd_select_d;

   logic [1:0]        rr_pick;
   logic [2:0]        owner_oh;
   logic              release_own;

   function automatic logic [2:0] to_onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    to_onehot = 3'b001;
         2'd1:    to_onehot = 3'b010;
         2'd2:    to_onehot = 3'b100;
         default: to_onehot = 3'b000;
      endcase
   endfunction

   // Pick the first requester after the last owner, so a forced-off owner goes to the back of the line
   always_comb begin
      logic       found;
      logic [1:0] cand;
      found   = 1'b0;
      cand    = 2'd0;
      rr_pick = 2'd0;
      for (int i = 1; i <= 3; i++) begin
         cand = 2'((int'(last_owner_q) + i) % 3);
         if (!found && bus.req[cand]) begin
            rr_pick = cand;
            found   = 1'b1;
         end
      end
   end

   // Release either after a completed hold with the owner idle, or on the ownership limit when others wait
   always_comb begin
      owner_oh    = to_onehot(owner_q);
      release_own = ((hold_cnt_q == HOLD_LAST) && !(|(bus.req & owner_oh))) ||
                    ((own_cnt_q == OWN_LAST) && (|(bus.req & ~owner_oh)));
   end

   // All state in one register bank; reset leaves requester 0 with first priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         owner_q        <= 2'd0;
         last_owner_q   <= 2'd2;
         hold_cnt_q     <= '0;
         own_cnt_q      <= '0;
         grant_q        <= 3'b000;
         display_data_q <= '0;
         lcd_select_q   <= 4'h0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         last_owner_q   <= last_owner_d;
         hold_cnt_q     <= hold_cnt_d;
         own_cnt_q      <= own_cnt_d;
         grant_q        <= grant_d;
         display_data_q <= display_data_d;
         lcd_select_q   <= lcd_select_d;
      end
   end

   // Next-state: arbitrate in IDLE, count and watch for release in OWN, spend exactly one cycle in GAP
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      hold_cnt_d   = hold_cnt_q;
      own_cnt_d    = own_cnt_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d    = OWN;
               owner_d    = rr_pick;
               hold_cnt_d = '0;
               own_cnt_d  = '0;
            end
         end
         OWN: begin
            hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
            own_cnt_d  = (own_cnt_q == OWN_LAST) ? own_cnt_q : own_cnt_q + 1'b1;
            if (release_own) begin
               state_d      = GAP;
               last_owner_d = owner_q;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: grant follows the upcoming state; the payload tracks the owner only while in OWN
   always_comb begin
      grant_d        = (state_d == OWN) ? to_onehot(owner_d) : 3'b000;
      display_data_d = display_data_q;
      lcd_select_d   = lcd_select_q;
      if (state_q == OWN) begin
         case (owner_q)
            2'd0: begin
               display_data_d = bus.data0;
               lcd_select_d   = bus.lcd0;
            end
            2'd1: begin
               display_data_d = bus.data1;
               lcd_select_d   = bus.lcd1;
            end
            default: begin
               display_data_d = bus.data2;
               lcd_select_d   = bus.lcd2;
            end
         endcase
      end
   end

   assign bus.grant        = grant_q;
   assign bus.busy         = |grant_q;
   assign bus.display_data = display_data_q;
   assign bus.lcd_select   = lcd_select_q;
endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter. Table-driven single-grant transactions are followed by
// hand-written sequences for forced release, long ownership, LCD tracking and asynchronous reset.
module tb_display_arbiter;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   display_arbiter_if #(.DATA_W(DW)) bus ();

   display_arbiter #(
      .HOLD_CYCLES(16),
      .MAX_OWN    (1024),
      .DATA_W     (DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      logic [2:0]    req;
      logic [DW-1:0] d0, d1, d2;
      logic [3:0]    l0, l1, l2;
      logic [2:0]    expGrant;
      logic [DW-1:0] expData;
      logic [3:0]    expLcd;
   } vec_t;

   vec_t       vecs[8];
   logic [2:0] expQ[$];
   int         total = 0;
   int         bad   = 0;

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pop the next expected grant from the scoreboard and compare
   task automatic popCheck(input string name, input logic [2:0] act);
      logic [2:0] e;
      if (expQ.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: got %0h expected none queued", name, act);
      end else begin
         e = expQ.pop_front();
         checkOutput(name, 64'(act), 64'(e));
      end
   endtask

   // Drive requests and payloads
   task automatic applyStimulus(input vec_t v);
      bus.req   = v.req;
      bus.data0 = v.d0;
      bus.data1 = v.d1;
      bus.data2 = v.d2;
      bus.lcd0  = v.l0;
      bus.lcd1  = v.l1;
      bus.lcd2  = v.l2;
   endtask

   // Hold reset for two cycles and release on a falling edge
   task automatic doReset();
      bus.req = 3'b000;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
   endtask

   initial begin
      int cnt;
      int w;
      int errs;
      int firstLen;
      int runLen;
      logic [2:0] g;
      logic [2:0] prev;

      // Grant winners follow round-robin from a reset last_owner of 2
      vecs[0] = '{3'b010, 32'h1111_0000, 32'h0000_1234, 32'h2222_0000, 4'h1, 4'h2, 4'h3, 3'b010, 32'h0000_1234, 4'h2};
      vecs[1] = '{3'b111, 32'h0000_A0A0, 32'h0000_B1B1, 32'h0000_C2C2, 4'h4, 4'h5, 4'h6, 3'b100, 32'h0000_C2C2, 4'h6};
      vecs[2] = '{3'b011, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 4'h7, 4'h8, 4'h9, 3'b001, 32'h0101_0101, 4'h7};
      vecs[3] = '{3'b101, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 4'hA, 4'hB, 4'hC, 3'b100, 32'hDEAD_0002, 4'hC};
      vecs[4] = '{3'b110, 32'hFFFF_0000, 32'hFFFF_0001, 32'hFFFF_0002, 4'hD, 4'hE, 4'hF, 3'b010, 32'hFFFF_0001, 4'hE};
      vecs[5] = '{3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 4'h3, 4'h0, 4'h0, 3'b001, 32'h1234_5678, 4'h3};
      vecs[6] = '{3'b001, 32'h8765_4321, 32'h0000_0000, 32'h0000_0000, 4'h8, 4'h0, 4'h0, 3'b001, 32'h8765_4321, 4'h8};
      vecs[7] = '{3'b100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'hF, 3'b100, 32'hFFFF_FFFF, 4'hF};

      bus.req = 3'b000;
      bus.data0 = '0; bus.data1 = '0; bus.data2 = '0;
      bus.lcd0 = 4'h0; bus.lcd1 = 4'h0; bus.lcd2 = 4'h0;
      #2 rst = 1'b1;
      @(negedge clk);
      checkOutput("reset_grant", 64'(bus.grant), 64'd0);
      checkOutput("reset_busy", 64'(bus.busy), 64'd0);
      checkOutput("reset_data", 64'(bus.display_data), 64'd0);
      checkOutput("reset_lcd", 64'(bus.lcd_select), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_no_req_grant", 64'(bus.grant), 64'd0);

      // Table: one-cycle request pulses, each held for the full hold window
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         expQ.push_back(vecs[i].expGrant);
         @(negedge clk);
         bus.req = 3'b000;
         popCheck($sformatf("vec%0d_grant", i), bus.grant);
         checkOutput($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd1);
         cnt = 0;
         while (bus.grant != 3'b000 && cnt < 100) begin
            cnt++;
            if (cnt == 2) begin
               checkOutput($sformatf("vec%0d_data", i), 64'(bus.display_data), 64'(vecs[i].expData));
               checkOutput($sformatf("vec%0d_lcd", i), 64'(bus.lcd_select), 64'(vecs[i].expLcd));
            end
            @(negedge clk);
         end
         checkOutput($sformatf("vec%0d_hold_len", i), 64'(cnt), 64'd16);
         bus.data0 = ~bus.data0; bus.data1 = ~bus.data1; bus.data2 = ~bus.data2;
         bus.lcd0 = ~bus.lcd0; bus.lcd1 = ~bus.lcd1; bus.lcd2 = ~bus.lcd2;
         @(negedge clk);
         checkOutput($sformatf("vec%0d_data_held", i), 64'(bus.display_data), 64'(vecs[i].expData));
         checkOutput($sformatf("vec%0d_lcd_held", i), 64'(bus.lcd_select), 64'(vecs[i].expLcd));
      end

      // All three requesting continuously: forced rotation 001, 010, 100, 001
      doReset();
      expQ.push_back(3'b001); expQ.push_back(3'b010);
      expQ.push_back(3'b100); expQ.push_back(3'b001);
      bus.req = 3'b111;
      prev = 3'b000; errs = 0; firstLen = -1; runLen = 0; cnt = 0;
      while (expQ.size() > 0 && cnt < 6000) begin
         @(negedge clk);
         cnt++;
         g = bus.grant;
         if ($countones(g) > 1 || bus.busy != (|g)) errs++;
         if (g != 3'b000 && prev == 3'b000) begin
            popCheck("rr_all_grant", g);
            runLen = 0;
         end
         if (g != 3'b000) runLen++;
         if (g == 3'b000 && prev != 3'b000 && firstLen < 0) firstLen = runLen;
         prev = g;
      end
      checkOutput("rr_all_pending", 64'(expQ.size()), 64'd0);
      checkOutput("rr_all_force_len", 64'(firstLen), 64'd1024);
      checkOutput("rr_all_onehot_busy_errs", 64'(errs), 64'd0);

      // Owner 0 held, requester 2 arrives at ownership cycle 100
      doReset();
      bus.req = 3'b001;
      expQ.push_back(3'b001);
      @(negedge clk);
      popCheck("force_first_grant", bus.grant);
      cnt = 0;
      while (bus.grant == 3'b001 && cnt < 2000) begin
         cnt++;
         if (cnt == 100) begin
            bus.req = 3'b101;
            expQ.push_back(3'b100);
         end
         @(negedge clk);
      end
      checkOutput("force_own_len", 64'(cnt), 64'd1024);
      w = 0;
      while (bus.grant == 3'b000 && w < 10) begin
         w++;
         @(negedge clk);
      end
      popCheck("force_next_grant", bus.grant);

      // Requester 1 alone for 5000 cycles keeps the grant with no gap
      doReset();
      bus.lcd1 = 4'h2;
      bus.req = 3'b010;
      @(negedge clk);
      checkOutput("solo_grant", 64'(bus.grant), 64'b010);
      errs = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (bus.grant != 3'b010) errs++;
      end
      checkOutput("solo_hold_errs", 64'(errs), 64'd0);

      // LCD select tracks the owner, then freezes through GAP
      checkOutput("lcd_track_before", 64'(bus.lcd_select), 64'h2);
      bus.lcd1 = 4'h5;
      @(negedge clk);
      checkOutput("lcd_track_after", 64'(bus.lcd_select), 64'h5);
      bus.req = 3'b000;
      @(negedge clk);
      checkOutput("lcd_gap_grant", 64'(bus.grant), 64'd0);
      bus.lcd1 = 4'h9;
      @(negedge clk);
      checkOutput("lcd_gap_held", 64'(bus.lcd_select), 64'h5);

      // Asynchronous reset mid-ownership, then requester 0 wins first
      doReset();
      bus.lcd2 = 4'h7;
      bus.req = 3'b100;
      @(negedge clk);
      checkOutput("arst_pre_grant", 64'(bus.grant), 64'b100);
      @(negedge clk);
      checkOutput("arst_pre_lcd", 64'(bus.lcd_select), 64'h7);
      rst = 1'b1;
      #1;
      checkOutput("arst_grant", 64'(bus.grant), 64'd0);
      checkOutput("arst_lcd", 64'(bus.lcd_select), 64'd0);
      checkOutput("arst_busy", 64'(bus.busy), 64'd0);
      bus.req = 3'b101;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("arst_first_grant", 64'(bus.grant), 64'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
